// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encodings and sizing helpers for the convolution engine
package conv_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_W = 3'd1;
    localparam logic [2:0] S_WT_W = 3'd2;
    localparam logic [2:0] S_RD_P = 3'd3;
    localparam logic [2:0] S_WT_P = 3'd4;
    localparam logic [2:0] S_MAC  = 3'd5;
    localparam logic [2:0] S_WR   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    function automatic int out_dim(input int in_sz, input int knl, input int stride);
        return (in_sz - knl) / stride + 1;
    endfunction

    function automatic int acc_width(input int dw, input int taps);
        return 2 * dw + $clog2(taps);
    endfunction

    function automatic longint fx_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint fx_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: clear/accumulate datapath with fixed-point rescale, saturation and optional ReLU
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ACC_WIDTH  = 69
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  acc_en_i,
    input  logic                  relu_i,
    input  logic [DATA_WIDTH-1:0] w_i,
    input  logic [DATA_WIDTH-1:0] p_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(fx_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(fx_min(DATA_WIDTH));

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] sh;
    logic        [DATA_WIDTH-1:0] sat;

    assign prod = PW'($signed(w_i)) * PW'($signed(p_i));

    // accumulator: cleared at each new pixel, sign-extended product added per tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else if (acc_en_i) acc_q <= acc_q + ACC_WIDTH'(prod);
    end

    // rescale to the word format, clamp to its range, then optionally drop negatives
    always_comb begin
        sh    = acc_q >>> FRAC_BITS;
        sat   = sh > HI ? HI[DATA_WIDTH-1:0] : sh < LO ? LO[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
        res_o = relu_i && sat[DATA_WIDTH-1] ? '0 : sat;
    end

endmodule

// File: rtl/conv_engine.sv
// conv_engine: multi-channel 2-D convolution layer controller with DRAM read/write handshake
module conv_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ADDR_WIDTH = 18,
    parameter int KNL_W      = 5,
    parameter int KNL_H      = 5,
    parameter int IFMAP_W    = 32,
    parameter int IFMAP_H    = 32,
    parameter int IN_CHNL    = 1,
    parameter int OUT_CHNL   = 16,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  relu_en_i,
    input  logic [ADDR_WIDTH-1:0] knl_base_i,
    input  logic [ADDR_WIDTH-1:0] ifmap_base_i,
    input  logic [ADDR_WIDTH-1:0] ofmap_base_i,
    input  logic                  dram_valid_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    output logic                  dram_en_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_in_o,
    output logic                  dram_en_wr_o,
    output logic [ADDR_WIDTH-1:0] addr_out_o,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int OW   = out_dim(IFMAP_W, KNL_W, STRIDE);
    localparam int OH   = out_dim(IFMAP_H, KNL_H, STRIDE);
    localparam int TAPS = IN_CHNL * KNL_W * KNL_H;
    localparam int ACCW = acc_width(DATA_WIDTH, TAPS);
    localparam int CW   = 16;
    // address jumps applied when the kernel row, kernel plane or output row wraps
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_KY   = ADDR_WIDTH'(IFMAP_W - KNL_W + 1);
    localparam logic [ADDR_WIDTH-1:0] A_IC   = ADDR_WIDTH'(IFMAP_H * IFMAP_W - (KNL_H - 1) * IFMAP_W - (KNL_W - 1));
    localparam logic [ADDR_WIDTH-1:0] A_OX   = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] A_OY   = ADDR_WIDTH'(STRIDE * IFMAP_W - (OW - 1) * STRIDE);
    localparam logic [ADDR_WIDTH-1:0] A_TAPS = ADDR_WIDTH'(TAPS);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         kx_q, ky_q, ic_q, ox_q, oy_q, oc_q;
    logic [ADDR_WIDTH-1:0] w_addr_q, wb_q, p_addr_q, pix_q, ifb_q, o_addr_q, pix_d, wb_d;
    logic [DATA_WIDTH-1:0] w_q, p_q, res;
    logic                  relu_q, start, last_kx, last_ky, last_ic, last_tap, last_ox, last_oy, last_oc, plane_end;

    assign start     = enable_i && (state_q == S_IDLE || state_q == S_DONE);
    assign last_kx   = kx_q == CW'(KNL_W - 1);
    assign last_ky   = ky_q == CW'(KNL_H - 1);
    assign last_ic   = ic_q == CW'(IN_CHNL - 1);
    assign last_tap  = last_kx && last_ky && last_ic;
    assign last_ox   = ox_q == CW'(OW - 1);
    assign last_oy   = oy_q == CW'(OH - 1);
    assign last_oc   = oc_q == CW'(OUT_CHNL - 1);
    assign plane_end = last_ox && last_oy;
    assign pix_d     = plane_end ? ifb_q : last_ox ? pix_q + A_OY : pix_q + A_OX;
    assign wb_d      = plane_end ? wb_q + A_TAPS : wb_q;

    // next-state logic: one read per tap operand, one write per output pixel
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start ? S_RD_W : S_IDLE;
            S_RD_W:         state_d = S_WT_W;
            S_WT_W:         state_d = dram_valid_i ? S_RD_P : S_WT_W;
            S_RD_P:         state_d = S_WT_P;
            S_WT_P:         state_d = dram_valid_i ? S_MAC : S_WT_P;
            S_MAC:          state_d = last_tap ? S_WR : S_RD_W;
            S_WR:           state_d = plane_end && last_oc ? S_DONE : S_RD_W;
            default:        state_d = S_IDLE;
        endcase
    end

    // state register; reset aborts any layer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // loop counters, incremental address generators and operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {kx_q, ky_q, ic_q, ox_q, oy_q, oc_q} <= '0;
            {w_addr_q, wb_q, p_addr_q, pix_q, ifb_q, o_addr_q} <= '0;
            {w_q, p_q} <= '0;
            relu_q <= 1'b0;
        end else begin
            if (start) begin
                relu_q   <= relu_en_i;
                ifb_q    <= ifmap_base_i;
                pix_q    <= ifmap_base_i;
                p_addr_q <= ifmap_base_i;
                wb_q     <= knl_base_i;
                w_addr_q <= knl_base_i;
                o_addr_q <= ofmap_base_i;
            end
            if (state_q == S_WT_W && dram_valid_i) w_q <= data_in_i;
            if (state_q == S_WT_P && dram_valid_i) p_q <= data_in_i;
            if (state_q == S_MAC) begin
                kx_q     <= last_kx ? '0 : kx_q + CW'(1);
                ky_q     <= last_kx ? (last_ky ? '0 : ky_q + CW'(1)) : ky_q;
                ic_q     <= last_kx && last_ky ? (last_ic ? '0 : ic_q + CW'(1)) : ic_q;
                w_addr_q <= w_addr_q + A_ONE;
                p_addr_q <= last_kx && last_ky ? p_addr_q + A_IC : last_kx ? p_addr_q + A_KY : p_addr_q + A_ONE;
            end
            if (state_q == S_WR) begin
                ox_q     <= last_ox ? '0 : ox_q + CW'(1);
                oy_q     <= last_ox ? (last_oy ? '0 : oy_q + CW'(1)) : oy_q;
                oc_q     <= plane_end ? (last_oc ? '0 : oc_q + CW'(1)) : oc_q;
                pix_q    <= pix_d;
                p_addr_q <= pix_d;
                wb_q     <= wb_d;
                w_addr_q <= wb_d;
                o_addr_q <= o_addr_q + A_ONE;
            end
        end
    end

    conv_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_WIDTH (ACCW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start || state_q == S_WR),
        .acc_en_i(state_q == S_MAC),
        .relu_i  (relu_q),
        .w_i     (w_q),
        .p_i     (p_q),
        .res_o   (res)
    );

    assign dram_en_rd_o = state_q == S_RD_W || state_q == S_RD_P;
    assign addr_in_o    = state_q == S_RD_W ? w_addr_q : state_q == S_RD_P ? p_addr_q : '0;
    assign dram_en_wr_o = state_q == S_WR;
    assign addr_out_o   = dram_en_wr_o ? o_addr_q : '0;
    assign data_out_o   = dram_en_wr_o ? res : '0;
    assign busy_o       = state_q != S_IDLE;
    assign done_o       = state_q == S_DONE;

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed self-checking bench over three layer geometries
module tb_conv_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        relu = 1'b0;
    bit          jitter = 1'b0;
    logic [17:0] kb = 18'd100, ib = 18'd1000, ob = 18'd3000;
    logic [31:0] mem [0:4095];
    logic        en [3];
    logic        vld [3];
    logic [31:0] din [3];
    logic        rd [3];
    logic        wr [3];
    logic        busy [3];
    logic        done [3];
    logic [17:0] ra [3];
    logic [17:0] wa [3];
    logic [31:0] dout [3];
    logic [17:0] cap_a [$];
    logic [31:0] cap_d [$];
    logic [31:0] exp_d [18];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    conv_engine #(.KNL_W(3), .KNL_H(3), .IFMAP_W(3), .IFMAP_H(3), .IN_CHNL(1), .OUT_CHNL(1), .STRIDE(1)) u_a (
        .clk(clk), .rst(rst), .enable_i(en[0]), .relu_en_i(relu), .knl_base_i(kb), .ifmap_base_i(ib),
        .ofmap_base_i(ob), .dram_valid_i(vld[0]), .data_in_i(din[0]), .dram_en_rd_o(rd[0]), .addr_in_o(ra[0]),
        .dram_en_wr_o(wr[0]), .addr_out_o(wa[0]), .data_out_o(dout[0]), .busy_o(busy[0]), .done_o(done[0]));

    conv_engine #(.KNL_W(5), .KNL_H(5), .IFMAP_W(5), .IFMAP_H(5), .IN_CHNL(1), .OUT_CHNL(1), .STRIDE(1)) u_b (
        .clk(clk), .rst(rst), .enable_i(en[1]), .relu_en_i(relu), .knl_base_i(kb), .ifmap_base_i(ib),
        .ofmap_base_i(ob), .dram_valid_i(vld[1]), .data_in_i(din[1]), .dram_en_rd_o(rd[1]), .addr_in_o(ra[1]),
        .dram_en_wr_o(wr[1]), .addr_out_o(wa[1]), .data_out_o(dout[1]), .busy_o(busy[1]), .done_o(done[1]));

    conv_engine #(.KNL_W(2), .KNL_H(2), .IFMAP_W(6), .IFMAP_H(6), .IN_CHNL(2), .OUT_CHNL(2), .STRIDE(2)) u_c (
        .clk(clk), .rst(rst), .enable_i(en[2]), .relu_en_i(relu), .knl_base_i(kb), .ifmap_base_i(ib),
        .ofmap_base_i(ob), .dram_valid_i(vld[2]), .data_in_i(din[2]), .dram_en_rd_o(rd[2]), .addr_in_o(ra[2]),
        .dram_en_wr_o(wr[2]), .addr_out_o(wa[2]), .data_out_o(dout[2]), .busy_o(busy[2]), .done_o(done[2]));

    // DRAM read model per engine: optional random latency, garbage data and stray valids when idle
    for (genvar g = 0; g < 3; g++) begin : resp
        logic        pend;
        int          cnt;
        logic [17:0] adr;
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                pend   <= 1'b0;
                cnt    <= 0;
                adr    <= '0;
                vld[g] <= 1'b0;
                din[g] <= '0;
            end else begin
                vld[g] <= 1'b0;
                din[g] <= 32'hDEAD_BEEF;
                if (rd[g]) begin
                    pend <= 1'b1;
                    adr  <= ra[g];
                    cnt  <= jitter ? int'($urandom_range(0, 7)) : 0;
                end else if (pend) begin
                    if (cnt == 0) begin
                        vld[g] <= 1'b1;
                        din[g] <= mem[adr[11:0]];
                        pend   <= 1'b0;
                    end else cnt <= cnt - 1;
                end else if (jitter && $urandom_range(0, 2) == 0) vld[g] <= 1'b1;
            end
        end
    end

    // write capture across all engines, in issue order
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) if (wr[i]) begin
            cap_a.push_back(wa[i]);
            cap_d.push_back(dout[i]);
        end
    end

    function automatic int wv(input int a);
        return (a % 5) - 2;
    endfunction

    function automatic int pv(input int a);
        return (a % 7) - 3;
    endfunction

    task automatic fill(input int n, input logic [31:0] w, input logic [31:0] p);
        for (int i = 0; i < n; i++) begin
            mem[100 + i]  = w;
            mem[1000 + i] = p;
        end
    endtask

    // called on a falling edge; returns on the falling edge where done is seen
    task automatic run_layer(input int which, input int poke, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        cap_a.delete();
        cap_d.delete();
        en[which] = 1'b1;
        while (!got && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            en[which] = (cyc == poke);
            got = done[which];
        end
        en[which] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rd[i], wr[i], busy[i], done[i]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_ctrl[%0d] got=%b want=0000", i, {rd[i], wr[i], busy[i], done[i]});
            end
            total++;
            if ({ra[i], wa[i], dout[i]} !== 68'h0) begin
                bad++;
                $display("FAIL reset_bus[%0d] got=%h want=0", i, {ra[i], wa[i], dout[i]});
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ones(input int poke, input string tag);
        bit got;
        int cyc;
        fill(9, 32'h0001_0000, 32'h0001_0000);
        relu = 1'b0;
        run_layer(0, poke, got, cyc);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL %s_done got=%0b want=1", tag, got); end
        total++; if (cyc !== 65) begin bad++; $display("FAIL %s_cycles got=%0d want=65", tag, cyc); end
        total++; if (cap_d.size() !== 1) begin bad++; $display("FAIL %s_nwr got=%0d want=1", tag, cap_d.size()); end
        total++; if (cap_a[0] !== 18'd3000) begin bad++; $display("FAIL %s_addr got=%0d want=3000", tag, cap_a[0]); end
        total++; if (cap_d[0] !== 32'h0009_0000) begin bad++; $display("FAIL %s_data got=%h want=00090000", tag, cap_d[0]); end
        @(negedge clk);
        total++;
        if ({done[0], busy[0]} !== 2'b00) begin
            bad++;
            $display("FAIL %s_after got=%b want=00", tag, {done[0], busy[0]});
        end
    endtask

    task automatic test_relu;
        bit got;
        int cyc;
        fill(9, 32'hFFFF_0000, 32'h0001_0000);
        relu = 1'b1;
        run_layer(0, -1, got, cyc);
        relu = 1'b0;
        total++; if (cap_d.size() !== 1 || cap_d[0] !== 32'h0) begin bad++; $display("FAIL relu_on got=%h want=00000000", cap_d[0]); end
        @(negedge clk);
        run_layer(0, -1, got, cyc);
        total++; if (cap_d.size() !== 1 || cap_d[0] !== 32'hFFF7_0000) begin bad++; $display("FAIL relu_off got=%h want=fff70000", cap_d[0]); end
        @(negedge clk);
    endtask

    task automatic test_shift;
        bit got;
        int cyc;
        fill(9, 32'h0, 32'h1);
        mem[100] = 32'hFFFF_FFFF;
        run_layer(0, -1, got, cyc);
        total++; if (cap_d.size() !== 1 || cap_d[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL arith_shift got=%h want=ffffffff", cap_d[0]); end
        @(negedge clk);
    endtask

    task automatic test_saturate;
        bit got;
        int cyc;
        fill(25, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_layer(1, -1, got, cyc);
        total++; if (cyc !== 177) begin bad++; $display("FAIL sat_cycles got=%0d want=177", cyc); end
        total++; if (cap_d.size() !== 1 || cap_d[0] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos got=%h want=7fffffff", cap_d[0]); end
        @(negedge clk);
        fill(25, 32'h8000_0000, 32'h7FFF_FFFF);
        run_layer(1, -1, got, cyc);
        total++; if (cap_d.size() !== 1 || cap_d[0] !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg got=%h want=80000000", cap_d[0]); end
        @(negedge clk);
        relu = 1'b1;
        run_layer(1, -1, got, cyc);
        relu = 1'b0;
        total++; if (cap_d.size() !== 1 || cap_d[0] !== 32'h0) begin bad++; $display("FAIL sat_neg_relu got=%h want=00000000", cap_d[0]); end
        @(negedge clk);
    endtask

    task automatic test_stride(input bit jit, input string tag);
        bit got;
        int cyc;
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        for (int a = 100; a < 116; a++) mem[a] = 32'(wv(a) * 65536);
        for (int a = 1000; a < 1072; a++) mem[a] = 32'(pv(a) * 65536);
        for (int oc = 0; oc < 2; oc++)
            for (int oy = 0; oy < 3; oy++)
                for (int ox = 0; ox < 3; ox++) begin
                    int s = 0;
                    for (int ic = 0; ic < 2; ic++)
                        for (int ky = 0; ky < 2; ky++)
                            for (int kx = 0; kx < 2; kx++)
                                s += wv(100 + ((oc * 2 + ic) * 2 + ky) * 2 + kx) * pv(1000 + (ic * 6 + oy * 2 + ky) * 6 + ox * 2 + kx);
                    exp_d[(oc * 3 + oy) * 3 + ox] = 32'(s * 65536);
                end
        jitter = jit;
        run_layer(2, -1, got, cyc);
        jitter = 1'b0;
        total++; if (got !== 1'b1) begin bad++; $display("FAIL %s_done got=%0b want=1", tag, got); end
        if (!jit) begin
            total++; if (cyc !== 1027) begin bad++; $display("FAIL %s_cycles got=%0d want=1027", tag, cyc); end
        end
        total++; if (cap_d.size() !== 18) begin bad++; $display("FAIL %s_nwr got=%0d want=18", tag, cap_d.size()); end
        for (int n = 0; n < 18 && n < cap_d.size(); n++) begin
            total++; if (cap_a[n] !== 18'(3000 + n)) begin bad++; $display("FAIL %s_addr[%0d] got=%0d want=%0d", tag, n, cap_a[n], 3000 + n); end
            total++; if (cap_d[n] !== exp_d[n]) begin bad++; $display("FAIL %s_data[%0d] got=%h want=%h", tag, n, cap_d[n], exp_d[n]); end
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        cap_a.delete();
        cap_d.delete();
        fill(9, 32'h0001_0000, 32'h0001_0000);
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rd[0], wr[0], busy[0], done[0], ra[0], wa[0], dout[0]} !== 72'h0) begin
            bad++;
            $display("FAIL abort_outputs got=%h want=0", {rd[0], wr[0], busy[0], done[0], ra[0], wa[0], dout[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (cap_d.size() !== 0) begin bad++; $display("FAIL abort_nwr got=%0d want=0", cap_d.size()); end
        test_ones(-1, "rerun");
    endtask

    initial begin
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        test_reset();
        test_ones(-1, "ones");
        test_ones(10, "busy_ignore");
        test_relu();
        test_shift();
        test_saturate();
        test_stride(1'b0, "stride");
        test_stride(1'b1, "jitter");
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
